out_display_queue: RTL
======================

# out_display_queue

Output-port stage downstream of the `simple` processor core. It captures each 16-bit value the core emits on its OUT strobe into a small FIFO, and shows the oldest unread value as four hex digits on the board's 32-bit seven-segment bus. A push-button steps through queued values. Back-pressure (`wr_ready`) lets the core's phase sequencer hold an OUT instruction while the queue is full.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2
- `DEBOUNCE_CYCLES`, 50000: stable-cycles required on `next_n`; used only with `OUTQ_DEBOUNCE_EN`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `wr_valid` in 1: core OUT strobe
- `wr_data` in 16: value to output
- `wr_ready` out 1: `~full`, registered
- `next_n` in 1: active-low push-button, asynchronous to `clk`
- `clear` in 1: synchronous flush
- `seg_out` out 32: digit3 in [31:24] … digit0 in [7:0]; each byte `{dp,g,f,e,d,c,b,a}`, active-low
- `empty` out 1, `full` out 1
- `count` out log2(DEPTH)+1: entries held
- `overflow` out 1: sticky, a write was dropped

## Operation
- Reset values: `seg_out`=32'hFFFF_FFFF (blank), `wr_ready`=1, `empty`=1, `full`=0, `count`=0, `overflow`=0, pointers 0, button state released.
- Push: on a posedge with `wr_valid & wr_ready`, `wr_data` is written at the write pointer, which then increments and wraps modulo DEPTH.
- Drop: `wr_valid & ~wr_ready` sets `overflow`. The data is discarded and the FIFO is unchanged.
- Pop: a qualified press with `~empty` advances the read pointer, wrapping modulo DEPTH. A press while empty is ignored.
- Simultaneous push and pop are decided on registered flags:
  - Full: pop occurs, push is rejected (`wr_ready` was 0), `overflow` is set.
  - Empty: push occurs, pop is ignored.
  - Otherwise: both occur and `count` is unchanged.
- `clear` empties the FIFO and zeroes `count` and `overflow`. It has priority over push and pop in the same cycle. Stored data is not erased.
- Display:
  - Empty: `seg_out` is all 1s.
  - Otherwise: digit *k* shows head nibble [4k+3:4k] in hex.
  - Digit0 dp (bit 7) is driven 0 when `count` > 1, signalling that more values are pending. All other dp bits are 1.
- Hex codes (dp=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Button conditioning:
  - `next_n` passes through a 2-flop synchronizer.
  - The press pulse is one cycle wide, generated on the 1→0 transition of the conditioned level.
  - Holding the button produces exactly one pop.

## Timing
- Push at posedge N: `count`, `empty`, `full`, `wr_ready` update at N; `seg_out` reflects the new head at N+1 (registered decode).
- Pop latency, without debounce: `next_n` falls before posedge P → pop at P+2 → `seg_out` updated at P+3.
- Reset asserted mid-operation immediately forces all reset values. A press in flight is lost.
- `full` is asserted when `count`==DEPTH. `empty` is asserted when `count`==0. Both are registered, not derived from comparing pointers alone.

## Configuration
- `OUTQ_DEBOUNCE_EN` defined:
  - The synchronized level must hold unchanged for `DEBOUNCE_CYCLES` consecutive cycles before the conditioned level follows it.
  - Any change reloads the counter.
  - Pop latency becomes P+2+DEBOUNCE_CYCLES.
- Not defined: the conditioned level is the synchronized level directly, so glitches can produce extra pops. No counter is instantiated and `DEBOUNCE_CYCLES` is unused.

## Structure
- Package `outq_pkg` holds:
  - the 16-entry hex-to-segment constant table
  - `SEG_BLANK` = 8'hFF
  - `SEG_DP_BIT` = 7
  - the data width constant (16)
- Sub-module `outq_button`: synchronizer, optional debounce, edge detect. Output: one-cycle `press`. The FIFO and display logic stay in the top module.

## Test plan
- Reset → `seg_out`=FFFF_FFFF, `empty`=1, `count`=0, `wr_ready`=1; a press while empty leaves all outputs unchanged.
- Push 16'h12AF → next cycle `seg_out`=F9_A4_88_8E, `count`=1, digit0 dp=1.
- Push 16'h0003 after 16'h12AF → digit0 dp=0. Press → `seg_out`=C0_C0_C0_B0 at P+3, `count`=1.
- Fill 8 entries, then push 16'hFFFF → `wr_ready`=0, `overflow`=1, `count`=8. Eight presses show the entries in order, then blank. Pointers wrap correctly on a second fill.
- When full, apply `wr_valid` and a press in the same cycle → pop only, `count`=7, `overflow`=1. Then `clear` together with `wr_valid` → `count`=0, `overflow`=0, display blank.
- With `OUTQ_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4: a 3-cycle low glitch → no pop; a 10-cycle hold → exactly one pop.

Source files
------------

// File: rtl/outq_pkg.sv
// Shared constants for the output display queue: data width, seven-segment
// encodings (active-low {dp,g,f,e,d,c,b,a}) and a nibble-to-segment helper.
package outq_pkg;

    localparam int DATA_W = 16;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/outq_button.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce
// (OUTQ_DEBOUNCE_EN) and falling-edge detect producing a one-cycle press.
module outq_button
`ifdef OUTQ_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 50000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic next_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= next_n;
            sync2 <= sync1;
        end
    end

`ifdef OUTQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] stable_cnt;

    // Level follows the synchronized input only after it has differed for
    // DEBOUNCE_CYCLES consecutive samples; any return to the old level reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b1;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign press = level_q & ~level;

endmodule

// File: rtl/out_display_queue.sv
// Output FIFO for the core's OUT strobe with a registered four-digit hex
// seven-segment view of the head entry. Debounce option: OUTQ_DEBOUNCE_EN.
module out_display_queue
    import outq_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     next_n,
    input  logic                     clear,
    output logic [31:0]              seg_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("out_display_queue: DEPTH must be a power of two >= 2, DEBOUNCE_CYCLES >= 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              press;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] head;
    logic [31:0]       seg_next;

    outq_button
`ifdef OUTQ_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    )
`endif
    u_button (
        .clk   (clk),
        .rst   (rst),
        .next_n(next_n),
        .press (press)
    );

    // Write handshake: a word transfers on a rising edge where wr_valid and
    // wr_ready are both high; wr_valid with wr_ready low drops the word and
    // sets the sticky overflow flag. wr_ready is registered (~full).
    assign push = wr_valid & wr_ready;
    assign pop  = press & ~empty;

    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            wr_ready <= 1'b1;
            overflow <= 1'b0;
        end else if (clear) begin
            // Flush by aligning the read pointer; stored words stay in place.
            rd_ptr   <= wr_ptr;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            wr_ready <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == CNT_W'(DEPTH));
            wr_ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        seg_next = {hex_seg(head[15:12]), hex_seg(head[11:8]),
                    hex_seg(head[7:4]),   hex_seg(head[3:0])};
        if (count > CNT_W'(1)) begin
            seg_next[SEG_DP_BIT] = 1'b0;
        end
        if (empty) begin
            seg_next = {4{SEG_BLANK}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= {4{SEG_BLANK}};
        end else begin
            seg_out <= seg_next;
        end
    end

endmodule
